// File: rtl/mbtrain_sb_msg_arbiter.sv
// MBTRAIN sideband message arbiter: fixed-priority TX/RX grant to a single sideband encoder.
// Optional busy-rise timeout is enabled by defining SB_ARB_TIMEOUT_EN.
module mbtrain_sb_msg_arbiter #(
   parameter int unsigned MSG_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_valid_tx,
   input  logic [MSG_W-1:0] i_tx_msg,
   input  logic             i_valid_rx,
   input  logic [MSG_W-1:0] i_rx_msg,
   input  logic             i_sb_busy,
   output logic [MSG_W-1:0] o_sb_msg,
   output logic             o_sb_valid,
   output logic             o_sb_src,
   output logic             o_busy_negedge_detected,
   output logic             o_timeout
);

   typedef enum logic [2:0] {StIdle, StLaunch, StWaitHi, StWaitLo, StGap} state_e;

   state_e state_q;
   logic   busy_q;  // i_sb_busy delayed by one cycle, for falling-edge detection

`ifdef SB_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   // Holds the number of cycles elapsed since the launch cycle.
   logic [CntW-1:0] to_cnt_q;
   logic            to_hit;

   assign to_hit = (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign o_timeout          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q                 <= StIdle;
         busy_q                  <= 1'b0;
         o_sb_msg                <= '0;
         o_sb_valid              <= 1'b0;
         o_sb_src                <= 1'b0;
         o_busy_negedge_detected <= 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
         to_cnt_q                <= '0;
         o_timeout               <= 1'b0;
`endif
      end else begin
         busy_q                  <= i_sb_busy;
         o_sb_valid              <= 1'b0;
         o_busy_negedge_detected <= 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
         o_timeout               <= 1'b0;
`endif
         if (!i_en) begin
            // Abort: drop any transfer in flight without reporting completion.
            state_q  <= StIdle;
            o_sb_msg <= '0;
            o_sb_src <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (i_valid_tx && (i_tx_msg != '0)) begin
                     o_sb_msg   <= i_tx_msg;
                     o_sb_src   <= 1'b0;
                     o_sb_valid <= 1'b1;
                     state_q    <= StLaunch;
                  end else if (i_valid_rx && (i_rx_msg != '0)) begin
                     o_sb_msg   <= i_rx_msg;
                     o_sb_src   <= 1'b1;
                     o_sb_valid <= 1'b1;
                     state_q    <= StLaunch;
                  end
               end
               StLaunch: begin
                  state_q  <= StWaitHi;
`ifdef SB_ARB_TIMEOUT_EN
                  to_cnt_q <= CntW'(1);
`endif
               end
               StWaitHi: begin
                  if (i_sb_busy) begin
                     state_q <= StWaitLo;
`ifdef SB_ARB_TIMEOUT_EN
                  end else if (to_hit) begin
                     o_timeout <= 1'b1;
                     state_q   <= StGap;
                  end else begin
                     to_cnt_q <= to_cnt_q + CntW'(1);
`endif
                  end
               end
               StWaitLo: begin
                  if (busy_q && !i_sb_busy) begin
                     o_busy_negedge_detected <= 1'b1;
                     state_q                 <= StGap;
                  end
               end
               StGap: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mbtrain_sb_msg_arbiter.sv
// Scoreboard bench for mbtrain_sb_msg_arbiter: expected launches are queued at stimulus time
// and popped when o_sb_valid is observed.
module tb_mbtrain_sb_msg_arbiter;

   localparam int MSG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_en = 1'b0;
   logic             i_valid_tx = 1'b0;
   logic [MSG_W-1:0] i_tx_msg = '0;
   logic             i_valid_rx = 1'b0;
   logic [MSG_W-1:0] i_rx_msg = '0;
   logic             i_sb_busy = 1'b0;
   logic [MSG_W-1:0] o_sb_msg;
   logic             o_sb_valid;
   logic             o_sb_src;
   logic             o_busy_negedge_detected;
   logic             o_timeout;

   mbtrain_sb_msg_arbiter #(
      .MSG_W          (MSG_W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .i_en                    (i_en),
      .i_valid_tx              (i_valid_tx),
      .i_tx_msg                (i_tx_msg),
      .i_valid_rx              (i_valid_rx),
      .i_rx_msg                (i_rx_msg),
      .i_sb_busy               (i_sb_busy),
      .o_sb_msg                (o_sb_msg),
      .o_sb_valid              (o_sb_valid),
      .o_sb_src                (o_sb_src),
      .o_busy_negedge_detected (o_busy_negedge_detected),
      .o_timeout               (o_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;
   int n_launch = 0;
   int n_neg = 0;
   int n_to = 0;

   logic [MSG_W:0] exp_q[$];  // {src, msg}
   logic [MSG_W:0] mon_e;
   logic           prev_v = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Output monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (o_sb_valid === 1'b1) begin
         n_launch++;
         check("valid_one_cycle", {31'd0, prev_v}, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_launch", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("launch_msg", {28'd0, o_sb_msg}, {28'd0, mon_e[MSG_W-1:0]});
            check("launch_src", {31'd0, o_sb_src}, {31'd0, mon_e[MSG_W]});
         end
      end
      if (o_busy_negedge_detected === 1'b1) n_neg++;
      if (o_timeout === 1'b1) n_to++;
      prev_v = o_sb_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_launch(input int want_cyc, output int lc);
      for (int i = 0; i < 40 && o_sb_valid !== 1'b1; i++) step();
      lc = cyc;
      if (o_sb_valid !== 1'b1) check("launch_seen", 0, 1);
      else check("launch_cycle", lc, want_cyc);
   endtask

   task automatic wait_neg(input int want_cyc, output int pc);
      for (int i = 0; i < 20 && o_busy_negedge_detected !== 1'b1; i++) step();
      pc = cyc;
      if (o_busy_negedge_detected !== 1'b1) check("negedge_seen", 0, 1);
      else check("negedge_cycle", pc, want_cyc);
   endtask

   // Busy rises dly cycles after launch, stays high len cycles; returns the pulse cycle.
   task automatic serve(input int dly, input int len, output int pc);
      int fall;
      repeat (dly) step();
      i_sb_busy = 1'b1;
      repeat (len) step();
      i_sb_busy = 1'b0;
      fall = cyc;
      wait_neg(fall + 1, pc);
   endtask

   int lc, lc2, pc, pc2, d, bl, bn, bt;

   initial begin
      // Reset state
      repeat (3) step();
      check("rst_msg", {28'd0, o_sb_msg}, 0);
      check("rst_valid", {31'd0, o_sb_valid}, 0);
      check("rst_src", {31'd0, o_sb_src}, 0);
      check("rst_neg", {31'd0, o_busy_negedge_detected}, 0);
      check("rst_timeout", {31'd0, o_timeout}, 0);
      rst = 1'b0;
      step();

      // TX only
      bl = n_launch; bn = n_neg;
      i_en = 1'b1; i_valid_tx = 1'b1; i_tx_msg = 4'd1;
      exp_q.push_back({1'b0, 4'd1});
      d = cyc;
      wait_launch(d + 1, lc);
      serve(2, 5, pc);
      check("tx_msg_hold", {28'd0, o_sb_msg}, 1);
      check("tx_src_hold", {31'd0, o_sb_src}, 0);
      i_valid_tx = 1'b0;
      repeat (6) step();
      check("tx_launches", n_launch - bl, 1);
      check("tx_negedges", n_neg - bn, 1);

      // RX only
      bl = n_launch; bn = n_neg;
      i_valid_rx = 1'b1; i_rx_msg = 4'd2;
      exp_q.push_back({1'b1, 4'd2});
      d = cyc;
      wait_launch(d + 1, lc);
      serve(2, 4, pc);
      check("rx_msg_hold", {28'd0, o_sb_msg}, 2);
      check("rx_src_hold", {31'd0, o_sb_src}, 1);
      i_valid_rx = 1'b0;
      repeat (6) step();
      check("rx_launches", n_launch - bl, 1);
      check("rx_negedges", n_neg - bn, 1);

      // Both valid on the same edge: TX first, RX two cycles after the TX completion pulse
      bl = n_launch; bn = n_neg;
      i_valid_tx = 1'b1; i_tx_msg = 4'd1;
      i_valid_rx = 1'b1; i_rx_msg = 4'd2;
      exp_q.push_back({1'b0, 4'd1});
      exp_q.push_back({1'b1, 4'd2});
      d = cyc;
      wait_launch(d + 1, lc);
      serve(2, 3, pc);
      i_valid_tx = 1'b0;
      wait_launch(pc + 2, lc2);
      serve(2, 3, pc2);
      i_valid_rx = 1'b0;
      repeat (6) step();
      check("both_launches", n_launch - bl, 2);
      check("both_negedges", n_neg - bn, 2);

      // Abort from WAIT_LO
      bn = n_neg;
      i_valid_tx = 1'b1; i_tx_msg = 4'd3;
      exp_q.push_back({1'b0, 4'd3});
      d = cyc;
      wait_launch(d + 1, lc);
      step();
      i_sb_busy = 1'b1;
      step();
      step();
      i_en = 1'b0; i_valid_tx = 1'b0;
      step();
      check("abort_msg", {28'd0, o_sb_msg}, 0);
      check("abort_src", {31'd0, o_sb_src}, 0);
      check("abort_valid", {31'd0, o_sb_valid}, 0);
      i_sb_busy = 1'b0;
      repeat (5) step();
      check("abort_no_negedge", n_neg - bn, 0);
      i_en = 1'b1;
      step();

      // Zero message codes are ignored
      bl = n_launch;
      i_valid_tx = 1'b1; i_tx_msg = 4'd0;
      i_valid_rx = 1'b1; i_rx_msg = 4'd0;
      repeat (20) step();
      check("zero_no_launch", n_launch - bl, 0);
      i_valid_tx = 1'b0; i_valid_rx = 1'b0;
      step();

      // Asynchronous reset mid-transfer
      bl = n_launch;
      i_valid_rx = 1'b1; i_rx_msg = 4'd7;
      exp_q.push_back({1'b1, 4'd7});
      d = cyc;
      wait_launch(d + 1, lc);
      step();
      i_sb_busy = 1'b1;
      step();
      #2 rst = 1'b1;
      #1;
      check("arst_msg", {28'd0, o_sb_msg}, 0);
      check("arst_src", {31'd0, o_sb_src}, 0);
      i_valid_rx = 1'b0; i_sb_busy = 1'b0;
      step();
      rst = 1'b0;
      repeat (5) step();
      check("arst_launches", n_launch - bl, 1);

      // Busy never rises
      bl = n_launch; bt = n_to;
      i_valid_tx = 1'b1; i_tx_msg = 4'd5;
      exp_q.push_back({1'b0, 4'd5});
      d = cyc;
      wait_launch(d + 1, lc);
`ifdef SB_ARB_TIMEOUT_EN
      for (int i = 0; i < 30 && o_timeout !== 1'b1; i++) step();
      check("timeout_cycle", cyc, lc + 16);
      exp_q.push_back({1'b0, 4'd5});
      wait_launch(cyc + 2, lc2);
      step();
      check("timeout_pulses", n_to - bt, 1);
      check("timeout_launches", n_launch - bl, 2);
`else
      repeat (30) step();
      check("no_timeout", n_to - bt, 0);
      check("no_relaunch", n_launch - bl, 1);
`endif
      i_en = 1'b0; i_valid_tx = 1'b0;
      step();
      i_en = 1'b1;
      repeat (3) step();

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
